// File: rtl/dec_ctrl_pkg.sv
// Shared definitions for the countdown sequencer: controller state encoding
// and the width of the decrementer datapath.
package dec_ctrl_pkg;

  localparam int DEC_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seqState_t;

endpackage

// File: rtl/dec16_core.sv
// Combinational a-1 datapath built as a full-adder ripple of a + all-ones.
// borrow_out is high only when a is zero.
module dec16_core
  import dec_ctrl_pkg::*;
#(
  parameter int WIDTH = DEC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] dec_out,
  output logic             borrow_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  // With b tied to 1 each full adder reduces to sum=~(a^c), cout=a|c.
  for (genvar i = 0; i < WIDTH; i++) begin : gRipple
    assign dec_out[i]   = ~(a[i] ^ carry[i]);
    assign carry[i + 1] = a[i] | carry[i];
  end

  assign borrow_out = ~carry[WIDTH];

endmodule

// File: rtl/countdown_sequencer.sv
// Loadable countdown timer stepping a count through dec16_core once per prescaled tick.
// Define AUTO_RELOAD_EN to restart from the last loaded value after each done pulse.
module countdown_sequencer
  import dec_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  seqState_t          state;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   decOut;
  logic               borrowOut;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0]   reload;
`endif

  dec16_core #(.WIDTH(WIDTH)) uDec (
    .a          (count),
    .dec_out    (decOut),
    .borrow_out (borrowOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      presc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            count <= load_val;
            presc <= '0;
            busy  <= 1'b1;
`ifdef AUTO_RELOAD_EN
            reload <= load_val;
`endif
            if (load_val == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // abort outranks the terminal step; a borrow here means the count was corrupted.
          if (abort || borrowOut) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (presc == PRESC_LAST) begin
            presc <= '0;
            count <= decOut;
            if (decOut == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            presc <= presc + PRESC_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
`ifdef AUTO_RELOAD_EN
          if (!abort && reload != '0) begin
            count <= reload;
            presc <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: two instances (PRESCALE 1 and 3) checked every cycle
// against a timestamp-based model, plus literal expectations on directed sequences.
module tb_countdown_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count1, count3;
  logic        busy1, busy3, done1, done3;

  always #5 clk = ~clk;

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  countdown_sequencer #(.WIDTH(16), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .load_val(load_val),
    .count(count1), .busy(busy1), .done(done1)
  );

  countdown_sequencer #(.WIDTH(16), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .load_val(load_val),
    .count(count3), .busy(busy3), .done(done3)
  );

  int errors = 0;
  int checks = 0;

  // Model: an active count is described by its accept edge t0 and start value L;
  // k edges later the count is L - k/P, with done exactly at k == L*P.
  int edgeIdx = 0;
  int psc[2] = '{1, 3};
  bit mAct[2];
  int mT0[2], mL[2], mRel[2], mHeld[2];
  int expCount[2];
  bit expDone[2], expBusy[2];

  always @(posedge clk) begin : model
    int k;
    edgeIdx++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mAct[i]  = 1'b0;
        mHeld[i] = 0;
        mRel[i]  = 0;
      end else if (!mAct[i]) begin
        if (start && !abort) begin
          mAct[i] = 1'b1;
          mT0[i]  = edgeIdx;
          mL[i]   = int'(load_val);
          mRel[i] = int'(load_val);
        end
      end else begin
        k = edgeIdx - mT0[i];
        if (k - 1 == mL[i] * psc[i]) begin
          if (AUTO && !abort && mRel[i] != 0) begin
            mT0[i] = edgeIdx;
            mL[i]  = mRel[i];
          end else begin
            mAct[i]  = 1'b0;
            mHeld[i] = 0;
          end
        end else if (abort) begin
          mAct[i]  = 1'b0;
          mHeld[i] = mL[i] - (k - 1) / psc[i];
        end
      end
      if (mAct[i]) begin
        k = edgeIdx - mT0[i];
        expBusy[i]  = 1'b1;
        expDone[i]  = (k == mL[i] * psc[i]);
        expCount[i] = expDone[i] ? 0 : mL[i] - k / psc[i];
      end else begin
        expBusy[i]  = 1'b0;
        expDone[i]  = 1'b0;
        expCount[i] = mHeld[i];
      end
    end
  end

  bit    litEn = 1'b0;
  bit    litSel = 1'b0;
  int    litCount = 0;
  bit    litDone = 1'b0;
  bit    litBusy = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : compare
    check("count1", int'(count1), expCount[0]);
    check("busy1",  int'(busy1),  int'(expBusy[0]));
    check("done1",  int'(done1),  int'(expDone[0]));
    check("count3", int'(count3), expCount[1]);
    check("busy3",  int'(busy3),  int'(expBusy[1]));
    check("done3",  int'(done3),  int'(expDone[1]));
    if (litEn) begin
      check("lit_count", litSel ? int'(count3) : int'(count1), litCount);
      check("lit_busy",  litSel ? int'(busy3)  : int'(busy1),  int'(litBusy));
      check("lit_done",  litSel ? int'(done3)  : int'(done1),  int'(litDone));
    end
  end

  task automatic tick(input bit en, input int c, input bit d, input bit b);
    @(posedge clk);
    #1;
    litEn    = en;
    litCount = c;
    litDone  = d;
    litBusy  = b;
  endtask

  initial begin
    // reset held, then released with no stimulus
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    rst = 1'b0;
    repeat (3) tick(1, 0, 0, 0);

    // PRESCALE=1, load 5
    litSel = 1'b0;
    start = 1'b1; load_val = 16'd5;
    tick(1, 5, 0, 1);
    start = 1'b0;
    tick(1, 4, 0, 1);
    tick(1, 3, 0, 1);
    tick(1, 2, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 0, 1, 1);
    abort = 1'b1;
    tick(1, 0, 0, 0);
    abort = 1'b0;
    repeat (2) tick(0, 0, 0, 0);

    // PRESCALE=3, load 2
    litSel = 1'b1;
    start = 1'b1; load_val = 16'd2;
    tick(1, 2, 0, 1);
    start = 1'b0;
    tick(1, 2, 0, 1);
    tick(1, 2, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 0, 1, 1);
    abort = 1'b1;
    tick(1, 0, 0, 0);
    abort = 1'b0;
    repeat (2) tick(0, 0, 0, 0);

    // load 0: done next cycle, no wrap
    litSel = 1'b0;
    start = 1'b1; load_val = 16'd0;
    tick(1, 0, 1, 1);
    start = 1'b0;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);

    // load 10, abort at count 4, then start during abort
    start = 1'b1; load_val = 16'd10;
    tick(1, 10, 0, 1);
    start = 1'b0;
    for (int c = 9; c >= 4; c--) tick(1, c, 0, 1);
    abort = 1'b1; start = 1'b1; load_val = 16'd7;
    tick(1, 4, 0, 0);
    tick(1, 4, 0, 0);
    tick(1, 4, 0, 0);
    start = 1'b0; abort = 1'b0;
    tick(1, 4, 0, 0);

    // reset mid-count
    start = 1'b1; load_val = 16'd7;
    tick(1, 7, 0, 1);
    start = 1'b0;
    tick(1, 6, 0, 1);
    rst = 1'b1;
    tick(1, 0, 0, 0);
    rst = 1'b0;
    tick(1, 0, 0, 0);

    // full-scale load, first steps only
    start = 1'b1; load_val = 16'hFFFF;
    tick(1, 65535, 0, 1);
    start = 1'b0;
    tick(1, 65534, 0, 1);
    tick(1, 65533, 0, 1);
    abort = 1'b1;
    tick(1, 65533, 0, 0);
    abort = 1'b0;
    tick(1, 65533, 0, 0);

    // load 3, start during RUN ignored, reload behaviour
    start = 1'b1; load_val = 16'd3;
    tick(1, 3, 0, 1);
    load_val = 16'd9;
    tick(1, 2, 0, 1);
    start = 1'b0;
    tick(1, 1, 0, 1);
    tick(1, 0, 1, 1);
`ifdef AUTO_RELOAD_EN
    tick(1, 3, 0, 1);
    tick(1, 2, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 0, 1, 1);
    abort = 1'b1;
    tick(1, 0, 0, 0);
    abort = 1'b0;
    tick(1, 0, 0, 0);
`else
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
`endif
    repeat (12) tick(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
